// File: rtl/serial_subtractor.sv
// Bit-serial 16-bit subtractor r = A - B with borrow/zero/neg/ovf flags.
// One difference bit per cycle, LSB first, behind valid/ready handshakes on both sides.
module serial_subtractor (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   A,
  input  logic [15:0]   B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   r,
  output logic          borrow,
  output logic          zero,
  output logic          neg,
  output logic          ovf
);

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_sh, b_sh;
  logic [W-2:0]   pr;
  logic [CW-1:0]  cnt;
  logic           bw, sa, sb;

  logic           d_c, bw_nxt_c, last_c;
  logic [W-1:0]   res_c;

  // Next state plus the one-bit full-subtractor slice feeding the shift registers.
  always_comb begin
    state_nxt = state;
    d_c       = a_sh[0] ^ b_sh[0] ^ bw;
    bw_nxt_c  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bw);
    res_c     = {d_c, pr};
    last_c    = (cnt == CW'(W - 1));
    case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last_c)    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      pr        <= '0;
      cnt       <= '0;
      bw        <= 1'b0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      r         <= '0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= A;
            b_sh     <= B;
            sa       <= A[W-1];
            sb       <= B[W-1];
            bw       <= 1'b0;
            cnt      <= '0;
            pr       <= '0;
            in_ready <= 1'b0;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          pr   <= res_c[W-1:1];
          bw   <= bw_nxt_c;
          cnt  <= cnt + CW'(1);
          // Final bit: publish the result; flags use only latched signs.
          if (last_c) begin
            r         <= res_c;
            borrow    <= bw_nxt_c;
            zero      <= (res_c == '0);
            neg       <= res_c[W-1];
            ovf       <= (sa != sb) && (res_c[W-1] != sa);
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases plus random operands
// compared against plain 17-bit / signed integer arithmetic.
module tb_serial_subtractor;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A, B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] r;
  logic        borrow, zero, neg, ovf;

  int compared   = 0;
  int mismatched = 0;

  serial_subtractor dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .borrow(borrow), .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned 17-bit difference and true signed difference.
  task automatic check_res(input string tag, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] diff;
    int          sd;
    diff = {1'b0, a} - {1'b0, b};
    sd   = int'($signed(a)) - int'($signed(b));
    check({tag, ".r"},      32'(r),      32'(diff[15:0]));
    check({tag, ".borrow"}, 32'(borrow), 32'(diff[16]));
    check({tag, ".zero"},   32'(zero),   32'(diff[15:0] == 16'h0000));
    check({tag, ".neg"},    32'(neg),    32'(diff[15]));
    check({tag, ".ovf"},    32'(ovf),    32'((sd > 32767) || (sd < -32768)));
  endtask

  // Accept an operand pair and wait for the result, checking 16-edge latency.
  task automatic start_and_wait(input string tag, input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin step(); n++; end
    check({tag, ".in_ready"}, 32'(in_ready), 32'(1));
    A = a; B = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    A = 16'($urandom); B = 16'($urandom);
    check({tag, ".busy"}, 32'(in_ready), 32'(0));
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    check({tag, ".latency"}, 32'(n), 32'(16));
    check_res(tag, a, b);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b);
    start_and_wait(tag, a, b);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ".ov_clr"}, 32'(out_valid), 32'(0));
    check({tag, ".rdy_set"}, 32'(in_ready), 32'(1));
  endtask

  logic [15:0] qa[$], qb[$];
  int          acc[$];
  logic        took;
  logic [15:0] hr, ha, hb;
  logic [3:0]  hf;

  initial begin
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    step(); step();
    RST = 1'b0;
    check("rst.in_ready",  32'(in_ready),  32'(1));
    check("rst.out_valid", 32'(out_valid), 32'(0));
    check("rst.r",         32'(r),         32'(0));
    check("rst.flags",     32'({borrow, zero, neg, ovf}), 32'(0));

    run_op("d1234", 16'h1234, 16'h0034);
    run_op("d0m1",  16'h0000, 16'h0001);
    run_op("d8000", 16'h8000, 16'h0001);
    run_op("d7fff", 16'h7FFF, 16'hFFFF);
    run_op("d5555", 16'h5555, 16'h5555);
    check("keep.r", 32'(r), 32'(0));

    // Back-to-back with out_ready held high: accepts 18 edges apart.
    in_valid = 1'b1; out_ready = 1'b1;
    A = 16'($urandom); B = 16'($urandom);
    for (int e = 0; e < 60; e++) begin
      took = in_ready;
      ha = A; hb = B;
      step();
      if (took) begin
        acc.push_back(e); qa.push_back(ha); qb.push_back(hb);
        A = 16'($urandom); B = 16'($urandom);
      end
      if (out_valid && qa.size() > 0) check_res("b2b", qa.pop_front(), qb.pop_front());
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b.accepts", 32'(acc.size() >= 2), 32'(1));
    if (acc.size() >= 2) check("b2b.spacing", 32'(acc[1] - acc[0]), 32'(18));
    for (int i = 0; i < 20 && !(in_ready && !out_valid); i++) step();
    if (out_valid) begin out_ready = 1'b1; step(); out_ready = 1'b0; end

    // Stall in DONE while inputs churn.
    start_and_wait("stall", 16'hA5C3, 16'h3C5A);
    hr = r; hf = {borrow, zero, neg, ovf};
    for (int i = 0; i < 5; i++) begin
      A = 16'($urandom); B = 16'($urandom); in_valid = 1'($urandom_range(0, 1));
      step();
      check("stall.r",     32'(r), 32'(hr));
      check("stall.flags", 32'({borrow, zero, neg, ovf}), 32'(hf));
      check("stall.ov",    32'(out_valid), 32'(1));
      check("stall.rdy",   32'(in_ready),  32'(0));
    end
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("stall.ov_clr", 32'(out_valid), 32'(0));
    check("stall.rdy",    32'(in_ready),  32'(1));
    step();
    check("stall.noacc",  32'(in_ready),  32'(1));
    check("stall.keep_r", 32'(r), 32'(hr));

    // Reset in the 8th SHIFT cycle aborts the operation.
    A = 16'hFFFF; B = 16'h1234; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("mrst.in_ready",  32'(in_ready),  32'(1));
    check("mrst.out_valid", 32'(out_valid), 32'(0));
    check("mrst.r",         32'(r),         32'(0));
    check("mrst.flags",     32'({borrow, zero, neg, ovf}), 32'(0));
    for (int i = 0; i < 12; i++) begin
      step();
      check("mrst.idle_ov", 32'(out_valid), 32'(0));
    end
    run_op("post", 16'h0010, 16'h0001);

    for (int i = 0; i < 10; i++) run_op("rand", 16'($urandom), 16'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
